// File: rtl/hint_sprite_anim.sv
// -----------------------------------------------------------------------------
// hint_sprite_anim
//   Pipelined sprite/hint renderer for the VGA overlay path. Draws a
//   WIDTH x HEIGHT bitmap fetched from an external combinational ROM at
//   (posx, posy). It supports multi-frame animation, horizontal mirroring,
//   a transparent key colour, blinking, and a timed show/hide state machine.
//   The latency from scan coordinate to color/is_display is fixed at two
//   clocks.
//
// Ports
//   clk, rst_n        pixel clock (rising edge); asynchronous active-low reset
//   x, y              scan coordinate from vgac
//   posx, posy        top-left corner of the sprite (sampled every pixel)
//   isplay            master enable (level)
//   trigger           one-cycle pulse: start/restart a timed show
//   mirror            1 = horizontally flipped
//   blink_en          1 = blink while shown
//   rom_addr          registered ROM address (stage 1)
//   rom_data          combinational ROM data for rom_addr
//   color, is_display registered pixel colour / opaque flag (stage 2)
// -----------------------------------------------------------------------------
module hint_sprite_anim #(
    parameter int          WIDTH       = 224,
    parameter int          HEIGHT      = 28,
    parameter int          FRAMES      = 4,
    parameter int          ADDR_W      = 15,
    parameter int          FRAME_HOLD  = 8,
    parameter int          BLINK_HALF  = 16,
    parameter int          SHOW_FRAMES = 180,
    parameter logic [15:0] KEY_COLOR   = 16'hffff
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [9:0]        posx,
    input  logic [8:0]        posy,
    input  logic              isplay,
    input  logic              trigger,
    input  logic              mirror,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       color,
    output logic              is_display
);

    localparam int AW = (FRAMES > 1)      ? $clog2(FRAMES)          : 1;
    localparam int HW = (FRAME_HOLD > 1)  ? $clog2(FRAME_HOLD)      : 1;
    localparam int BW = (BLINK_HALF > 1)  ? $clog2(BLINK_HALF)      : 1;
    localparam int SW = (SHOW_FRAMES > 0) ? $clog2(SHOW_FRAMES + 1) : 1;

    localparam logic [AW-1:0] ANIM_LAST  = AW'(FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAME_HOLD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [SW-1:0] SHOW_LIM   = SW'(SHOW_FRAMES);
    localparam logic          TIMED      = (SHOW_FRAMES > 0);

    localparam logic [31:0] FRAME_PIX = 32'(WIDTH * HEIGHT);
    localparam logic [31:0] WIDTH32   = 32'(WIDTH);
    localparam logic [10:0] WIDTH11   = 11'(WIDTH);
    localparam logic [9:0]  HEIGHT10  = 10'(HEIGHT);
    localparam logic [9:0]  COL_LAST  = 10'(WIDTH - 1);

    typedef enum logic {ST_OFF, ST_ON} state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              isplay_q;
    logic              at00_q, at00_p_q;
    logic [SW-1:0]     show_q, show_d;
    logic [AW-1:0]     anim_q, anim_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              phase_q, phase_d;
    logic              vis_f_q, vis_f_d;

    logic              hit1_q, hit1_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       color_q, color_d;
    logic              disp_q, disp_d;

    // Frame tick: rising edge of the registered "scan is at (0,0)" flag.
    logic ftick;
    assign ftick = at00_q & ~at00_p_q;

    // ------------------------------------------------------------------
    // Show/hide FSM and per-frame counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        show_d  = show_q;
        anim_d  = anim_q;
        hold_d  = hold_q;
        blink_d = blink_q;
        phase_d = phase_q;
        vis_f_d = vis_f_q;

        unique case (state_q)
            ST_OFF: begin
                if (isplay && (trigger || (!TIMED && !isplay_q))) begin
                    state_d = ST_ON;
                    // An entry coinciding with a tick counts that tick.
                    show_d  = ftick ? SW'(1) : '0;
                    anim_d  = '0;
                    hold_d  = '0;
                    blink_d = '0;
                    phase_d = 1'b1;
                end
            end
            ST_ON: begin
                if (!isplay) begin
                    state_d = ST_OFF;
                end else begin
                    if (ftick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d = '0;
                            anim_d = (anim_q == ANIM_LAST) ? '0 : anim_q + AW'(1);
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end

                        if (blink_q == BLINK_LAST) begin
                            blink_d = '0;
                            phase_d = ~phase_q;
                        end else begin
                            blink_d = blink_q + BW'(1);
                        end

                        // Expiry is checked before counting, so the show
                        // covers SHOW_FRAMES full frames and the counter
                        // never passes its limit.
                        if (TIMED) begin
                            if (show_q == SHOW_LIM) state_d = ST_OFF;
                            else                    show_d  = show_q + SW'(1);
                        end
                    end
                    if (trigger) begin
                        state_d = ST_ON;
                        show_d  = ftick ? SW'(1) : '0;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Visibility latched once per frame from the post-tick state; a
        // dropped isplay clears it at once.
        if (!isplay)
            vis_f_d = 1'b0;
        else if (ftick)
            vis_f_d = (state_d == ST_ON) & (phase_d | ~blink_en);
    end

    // ------------------------------------------------------------------
    // Stage 1: hit test and ROM address
    // ------------------------------------------------------------------
    logic [10:0] x_ext, xl, xr;
    logic [9:0]  y_ext, yt, yb;
    logic [9:0]  dx, col;
    logic [8:0]  dy;
    logic        in_x, in_y;

    always_comb begin
        x_ext = {1'b0, x};
        xl    = {1'b0, posx};
        xr    = {1'b0, posx} + WIDTH11;
        y_ext = {1'b0, y};
        yt    = {1'b0, posy};
        yb    = {1'b0, posy} + HEIGHT10;
        in_x  = (x_ext >= xl) && (x_ext < xr);
        in_y  = (y_ext >= yt) && (y_ext < yb);
        dx    = x - posx;
        dy    = y - posy;
        col   = mirror ? (COL_LAST - dx) : dx;

        // isplay gates the hit directly so a drop empties the pipe in 2 edges.
        hit1_d     = vis_f_q & isplay & in_x & in_y;
        rom_addr_d = hit1_d ? ADDR_W'(32'(anim_q) * FRAME_PIX
                                      + 32'(dy) * WIDTH32
                                      + 32'(col))
                            : '0;
    end

    // ------------------------------------------------------------------
    // Stage 2: transparency key and colour
    // ------------------------------------------------------------------
    always_comb begin
        disp_d  = hit1_q && (rom_data != KEY_COLOR);
        color_d = disp_d ? rom_data : 16'hffff;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            isplay_q   <= 1'b0;
            at00_q     <= 1'b0;
            at00_p_q   <= 1'b0;
            show_q     <= '0;
            anim_q     <= '0;
            hold_q     <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b1;
            vis_f_q    <= 1'b0;
            hit1_q     <= 1'b0;
            rom_addr_q <= '0;
            color_q    <= 16'hffff;
            disp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            isplay_q   <= isplay;
            at00_q     <= (x == 10'd0) && (y == 9'd0);
            at00_p_q   <= at00_q;
            show_q     <= show_d;
            anim_q     <= anim_d;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            vis_f_q    <= vis_f_d;
            hit1_q     <= hit1_d;
            rom_addr_q <= rom_addr_d;
            color_q    <= color_d;
            disp_q     <= disp_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign color      = color_q;
    assign is_display = disp_q;

endmodule
